// File: rtl/alu_pkg.sv
// Shared op-codes and FSM state encoding for the execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MUL = 4'd2;
  localparam logic [3:0] ALU_SRL = 4'd3;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_AND = 4'd5;
  localparam logic [3:0] ALU_OR  = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_mult.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_step;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= CW'(WIDTH);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  // done/product are combinational on the final iteration so the caller can
  // register the finished product on the same edge as the last accumulate.
  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CW'(1));
  assign product = acc_step;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes and an iterative multiply.
// Define ALU_MUL_FAST_EN to compute mul combinationally in a single cycle.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sel_signal,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, alu_res, mul_product;
  logic             zero_q, zero_d, illegal_q, illegal_d, alu_ill;
  logic             accept, mul_start, mul_busy, mul_done;

  assign accept = in_valid & in_ready;

`ifdef ALU_MUL_FAST_EN
  assign mul_start   = 1'b0;
  assign mul_busy    = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`else
  assign mul_start = accept && (sel_signal == ALU_MUL);

  alu_seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (sel_signal)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
`ifdef ALU_MUL_FAST_EN
      ALU_MUL: alu_res = op_a * op_b;
`else
      ALU_MUL: alu_res = '0;
`endif
      ALU_SRL: alu_res = op_a >> op_b[SHW-1:0];
      ALU_SLL: alu_res = op_a << op_b[SHW-1:0];
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = mul_start ? ST_MUL : ST_DONE;
      ST_MUL:  if (mul_done) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = accept ? (mul_start ? ST_MUL : ST_DONE) : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result registers only move on a new single-cycle accept or a finished multiply.
  always_comb begin
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (accept && !mul_start) begin
      result_d  = alu_res;
      zero_d    = (alu_res == '0);
      illegal_d = alu_ill;
    end else if ((state_q == ST_MUL) && mul_done) begin
      result_d  = mul_product;
      zero_d    = (mul_product == '0);
      illegal_d = 1'b0;
    end
  end

  assign in_ready  = ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready)) && !mul_busy;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table plus hand-written stall, mul, reset and streaming sequences.
module tb_alu_exec_unit;

  localparam int W = 32;
`ifdef ALU_MUL_FAST_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    sel_signal = 4'd0;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic          zero;
  logic          illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W), .SHW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel_signal (sel_signal),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_zero;
    logic         exp_ill;
  } vec_t;

  vec_t vecs[14];
  vec_t muls[3];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    logic bad_ready;

    vecs[0]  = '{4'd0, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0};
    vecs[1]  = '{4'd1, 32'd7,         32'd7,         32'd0,         1'b1, 1'b0};
    vecs[2]  = '{4'd7, 32'hFFFFFFFF,  32'd1,         32'd1,         1'b0, 1'b0};
    vecs[3]  = '{4'd7, 32'd1,         32'hFFFFFFFF,  32'd0,         1'b1, 1'b0};
    vecs[4]  = '{4'd3, 32'h80000000,  32'd31,        32'd1,         1'b0, 1'b0};
    vecs[5]  = '{4'd4, 32'd1,         32'd0,         32'd1,         1'b0, 1'b0};
    vecs[6]  = '{4'd4, 32'd1,         32'd31,        32'h80000000,  1'b0, 1'b0};
    vecs[7]  = '{4'd3, 32'h000000F0,  32'h00000023,  32'h0000001E,  1'b0, 1'b0};
    vecs[8]  = '{4'd5, 32'hF0F0F0F0,  32'h0FF00FF0,  32'h00F000F0,  1'b0, 1'b0};
    vecs[9]  = '{4'd6, 32'hF0F0F0F0,  32'h0FF00FF0,  32'hFFF0FFF0,  1'b0, 1'b0};
    vecs[10] = '{4'd0, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b0};
    vecs[11] = '{4'd1, 32'd0,         32'd1,         32'hFFFFFFFF,  1'b0, 1'b0};
    vecs[12] = '{4'd9, 32'd123,       32'd456,       32'd0,         1'b1, 1'b1};
    vecs[13] = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF,  32'd0,         1'b1, 1'b1};

    muls[0] = '{4'd2, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 1'b0};
    muls[1] = '{4'd2, 32'h12345678, 32'd9,        32'hA3D70A38, 1'b0, 1'b0};
    muls[2] = '{4'd2, 32'd0,        32'hDEADBEEF, 32'd0,        1'b1, 1'b0};

    // Reset state
    #22;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single-cycle op table, out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; sel_signal = vecs[i].op; op_a = vecs[i].a; op_b = vecs[i].b;
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_result", i), result, vecs[i].exp_res);
      chk($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].exp_zero});
      chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, vecs[i].exp_ill});
    end
    tick();
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Multiply: latency, in_ready low while busy, sel/operand changes ignored
    for (int m = 0; m < 3; m++) begin
      in_valid = 1'b1; sel_signal = muls[m].op; op_a = muls[m].a; op_b = muls[m].b;
      out_ready = 1'b0;
      tick();
      sel_signal = 4'd0; op_a = 32'd1; op_b = 32'd1;
      cyc = 1; bad_ready = 1'b0;
      while (!out_valid && cyc < 100) begin
        if (in_ready) bad_ready = 1'b1;
        tick();
        cyc++;
      end
      chk($sformatf("mul%0d_latency", m), cyc, MUL_LAT);
      chk($sformatf("mul%0d_in_ready_low", m), {31'd0, bad_ready}, 32'd0);
      chk($sformatf("mul%0d_result", m), result, muls[m].exp_res);
      chk($sformatf("mul%0d_zero", m), {31'd0, zero}, {31'd0, muls[m].exp_zero});
      chk($sformatf("mul%0d_illegal", m), {31'd0, illegal}, 32'd0);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk($sformatf("mul%0d_drain", m), {31'd0, out_valid}, 32'd0);
    end

    // Back-pressure: result held while out_ready low, pending op waits
    in_valid = 1'b1; sel_signal = 4'd0; op_a = 32'd3; op_b = 32'd4; out_ready = 1'b0;
    tick();
    sel_signal = 4'd1; op_a = 32'd100; op_b = 32'd1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall%0d_result", k), result, 32'd7);
      chk($sformatf("stall%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("stall_next_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_next_result", result, 32'd99);
    tick();

    // Reset in the middle of a multiply
    in_valid = 1'b1; sel_signal = 4'd2; op_a = 32'd6; op_b = 32'd7; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst_n = 1'b0;
    #2;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    bad_ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) bad_ready = 1'b1;
      tick();
    end
    chk("midrst_no_result", {31'd0, bad_ready}, 32'd0);

    // Streaming: four adds on consecutive cycles
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_valid = 1'b1; sel_signal = 4'd0; op_a = 32'(s + 1); op_b = 32'(10 * s);
      chk($sformatf("stream%0d_in_ready", s), {31'd0, in_ready}, 32'd1);
      tick();
      chk($sformatf("stream%0d_out_valid", s), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stream%0d_result", s), result, 32'(11 * s + 1));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_idle", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
